// File: rtl/detector_pkg.sv
// Shared constants and helpers for the serial pattern detector.
// The detector_shift header describes the optional DETECT_COUNT_EN counter.
package detector_pkg;
    localparam int COUNT_W = 8;

    // Increment that stops at all-ones instead of wrapping to zero.
    function automatic logic [COUNT_W-1:0] sat_inc(input logic [COUNT_W-1:0] v);
        return (v == '1) ? v : v + COUNT_W'(1);
    endfunction
endpackage

// File: rtl/detector_window.sv
// History window: the PAT_W-bit shift register plus a fill counter that saturates at PAT_W.
// o_*_nxt expose the state that the next edge will load, so the parent can register its compare result.
module detector_window
    import detector_pkg::*;
#(
    parameter int PAT_W  = 4,
    parameter int FILL_W = $clog2(PAT_W + 1)
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              din_bit,
    input  logic              i_restart,
    output logic [PAT_W-1:0]  o_shift_nxt,
    output logic [FILL_W-1:0] o_fill_nxt
);
    logic [PAT_W-1:0]  r_shift;
    logic [FILL_W-1:0] r_fill;
    logic [PAT_W-1:0]  w_shift_base;
    logic [FILL_W-1:0] w_fill_base;

    // On restart the new bit goes into an empty window, so no bit of the
    // previous match can be reused.
    always_comb begin
        w_shift_base = i_restart ? '0 : r_shift;
        w_fill_base  = i_restart ? '0 : r_fill;
        o_shift_nxt  = {w_shift_base[PAT_W-2:0], din_bit};
        o_fill_nxt   = (w_fill_base == FILL_W'(PAT_W)) ? w_fill_base
                                                       : w_fill_base + FILL_W'(1);
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_shift <= '0;
            r_fill  <= '0;
        end else begin
            r_shift <= o_shift_nxt;
            r_fill  <= o_fill_nxt;
        end
    end
endmodule

// File: rtl/detector_shift.sv
// Serial bit-stream pattern detector with a registered, one-cycle detect pulse.
// Optional macro DETECT_COUNT_EN adds a saturating match_count output.
module detector_shift
    import detector_pkg::*;
#(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter bit               OVERLAP = 1'b1
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               din_bit,
`ifdef DETECT_COUNT_EN
    output logic [COUNT_W-1:0] match_count,
`endif
    output logic               detect_out
);
    localparam int FILL_W = $clog2(PAT_W + 1);

    logic [PAT_W-1:0]  w_shift_nxt;
    logic [FILL_W-1:0] w_fill_nxt;
    logic              w_match_nxt;
    logic              w_restart;
    logic              r_detect;

    // r_detect equals the match of the current window, so it is the restart
    // condition when overlapping matches are not allowed.
    assign w_restart = !OVERLAP && r_detect;

    detector_window #(.PAT_W(PAT_W), .FILL_W(FILL_W)) u_window (
        .clk         (clk),
        .reset       (reset),
        .din_bit     (din_bit),
        .i_restart   (w_restart),
        .o_shift_nxt (w_shift_nxt),
        .o_fill_nxt  (w_fill_nxt)
    );

    assign w_match_nxt = (w_fill_nxt == FILL_W'(PAT_W)) && (w_shift_nxt == PATTERN);

    always_ff @(posedge clk) begin
        if (!reset) r_detect <= 1'b0;
        else        r_detect <= w_match_nxt;
    end

    assign detect_out = r_detect;

`ifdef DETECT_COUNT_EN
    logic [COUNT_W-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!reset)        r_count <= '0;
        else if (r_detect) r_count <= sat_inc(r_count);
    end

    assign match_count = r_count;
`endif
endmodule

// File: tb/tb_detector_shift.sv
// Self-checking bench: four detector configurations share one stream and are
// compared each cycle against a bit-history reference model.
module tb_detector_shift;
    localparam int NI = 4;
    localparam logic [3:0] PATS [NI] = '{4'b1011, 4'b1011, 4'b0000, 4'b1111};
    localparam bit         OVS  [NI] = '{1'b1,    1'b0,    1'b1,    1'b1};

    logic clk = 1'b0;
    logic reset = 1'b0;
    logic din = 1'b0;
    logic [NI-1:0] det;
`ifdef DETECT_COUNT_EN
    logic [NI-1:0][7:0] cnt;
`endif

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        detector_shift #(.PAT_W(4), .PATTERN(PATS[g]), .OVERLAP(OVS[g])) u_dut (
            .clk         (clk),
            .reset       (reset),
            .din_bit     (din),
`ifdef DETECT_COUNT_EN
            .match_count (cnt[g]),
`endif
            .detect_out  (det[g])
        );
    end

    // Reference model: bits received since the last clear, newest in bit 0.
    bit [31:0] m_hist [NI];
    int        m_len  [NI];
    bit        m_det  [NI];
    int        m_cnt  [NI];
    int        n_checks = 0;
    int        n_fail   = 0;

    task automatic model_edge(input bit r, input bit d);
        for (int g = 0; g < NI; g++) begin
            if (!r) begin
                m_hist[g] = '0; m_len[g] = 0; m_det[g] = 1'b0; m_cnt[g] = 0;
            end else begin
                if (m_det[g] && m_cnt[g] < 255) m_cnt[g]++;
                if (!OVS[g] && m_det[g]) begin
                    m_hist[g] = '0; m_len[g] = 0;
                end
                m_hist[g] = {m_hist[g][30:0], d};
                m_len[g]++;
                m_det[g] = (m_len[g] >= 4) && (m_hist[g][3:0] == PATS[g]);
            end
        end
    endtask

    task automatic step(input bit r, input bit d);
        reset = r;
        din   = d;
        @(posedge clk);
        #1;
        model_edge(r, d);
        for (int g = 0; g < NI; g++) begin
            n_checks++;
            assert (det[g] === m_det[g]) else begin
                n_fail++;
                $error("FAIL det[%0d] observed %0b expected %0b", g, det[g], m_det[g]);
            end
`ifdef DETECT_COUNT_EN
            n_checks++;
            assert (cnt[g] === 8'(m_cnt[g])) else begin
                n_fail++;
                $error("FAIL cnt[%0d] observed %0d expected %0d", g, cnt[g], m_cnt[g]);
            end
`endif
        end
    endtask

    task automatic expect_det(input int g, input bit e, input string tag);
        n_checks++;
        assert (det[g] === e) else begin
            n_fail++;
            $error("FAIL %s det[%0d] observed %0b expected %0b", tag, g, det[g], e);
        end
    endtask

    initial begin
        bit s2 [16] = '{0,1,0,1,1,0,0,1,0,0,1,1,0,1,1,0};
        bit s3 [7]  = '{1,0,1,1,0,1,1};
        bit e3o [7] = '{0,0,0,1,0,0,1};
        bit e3n [7] = '{0,0,0,1,0,0,0};
        bit s5 [4]  = '{1,0,1,1};

        // Reset hold with toggling data
        step(1'b0, 1'b1);
        expect_det(0, 1'b0, "rst_hold0");
        step(1'b0, 1'b0);
        expect_det(3, 1'b0, "rst_hold1");

        // Default stream: detects after bits 4 and 14
        for (int i = 0; i < 16; i++) begin
            step(1'b1, s2[i]);
            expect_det(0, (i == 4 || i == 14), "stream");
        end
`ifdef DETECT_COUNT_EN
        n_checks++;
        assert (cnt[0] === 8'd2) else begin
            n_fail++;
            $error("FAIL stream_cnt observed %0d expected 2", cnt[0]);
        end
`endif

        // Overlap vs non-overlap
        step(1'b0, 1'b0);
        for (int i = 0; i < 7; i++) begin
            step(1'b1, s3[i]);
            expect_det(0, e3o[i], "overlap1");
            expect_det(1, e3n[i], "overlap0");
        end

        // All-zero pattern needs a full window after reset
        step(1'b0, 1'b1);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 1'b0);
            expect_det(2, (i == 3), "zero_pat");
        end

        // Reset mid-stream discards partial history
        step(1'b0, 1'b0);
        step(1'b1, 1'b1); step(1'b1, 1'b0); step(1'b1, 1'b1);
        step(1'b0, 1'b1);
        step(1'b1, 1'b1);
        expect_det(0, 1'b0, "mid_rst");
        step(1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b1, s5[i]);
            expect_det(0, (i == 3), "mid_rst_full");
        end

        // Random stream with occasional resets
        for (int i = 0; i < 400; i++)
            step(($urandom_range(0, 29) != 0), 1'($urandom_range(0, 1)));

        // Constant ones: back-to-back detects and counter saturation
        step(1'b0, 1'b0);
        for (int i = 0; i < 303; i++) begin
            step(1'b1, 1'b1);
            if (i >= 3) expect_det(3, 1'b1, "b2b");
        end
`ifdef DETECT_COUNT_EN
        n_checks++;
        assert (cnt[3] === 8'd255) else begin
            n_fail++;
            $error("FAIL sat_cnt observed %0d expected 255", cnt[3]);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
